// File: rtl/dot_mac16.sv
// dot_mac16: sequential signed dot-product engine.
// Operand pairs arrive over a valid/ready handshake. Each accepted pair is
// registered, multiplied by muls16 on the following cycle, and the product is
// added into a wide signed accumulator. The full sum and a 32-bit saturated
// copy are offered to a valid/ready consumer.

// Combinational signed 16x16 -> 32 multiplier.
module muls16 (
    input  logic signed [15:0] a_i,
    input  logic signed [15:0] b_i,
    output logic signed [31:0] p_o
);

    // Full-precision signed product; 32 bits cannot overflow for 16x16.
    assign p_o = 32'(a_i) * 32'(b_i);

endmodule

module dot_mac16 #(
    parameter int unsigned ACC_W = 40,
    parameter int unsigned LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      a,
    input  logic signed [15:0]      b,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_acc,
    output logic [31:0]             out_sat,
    output logic                    ovf
);

    localparam int unsigned PROD_W = 32;
    localparam int unsigned EXT_W  = ACC_W - PROD_W;
    localparam int unsigned TOP_W  = ACC_W - PROD_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [LEN_W-1:0]        count_q, count_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic signed [15:0]      a_q, a_d;
    logic signed [15:0]      b_q, b_d;
    logic                    p_valid_q, p_valid_d;

    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]        prod_ext;
    logic                    beat;
    logic                    last_beat;

    logic [TOP_W-1:0]        acc_top;
    logic                    in_range;
    logic [31:0]             sat_val;

    // Stage-2 multiplier operates on the registered operand pair.
    muls16 u_mul (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod)
    );

    // Sign-extend the product to accumulator width.
    assign prod_ext  = {{EXT_W{prod[PROD_W-1]}}, prod};

    // A beat is only possible while the engine is collecting pairs.
    assign beat      = (state_q == S_RUN) && in_valid;
    assign last_beat = beat && (count_q == (len_q - LEN_W'(1)));

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            len_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            p_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            len_q     <= len_d;
            a_q       <= a_d;
            b_q       <= b_d;
            p_valid_q <= p_valid_d;
        end
    end

    // Next-state logic: FSM sequencing, operand capture and accumulation.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        len_d     = len_q;
        a_d       = a_q;
        b_d       = b_q;
        p_valid_d = 1'b0;

        // A product captured on the previous edge accumulates on this one.
        if (p_valid_q) begin
            acc_d = acc_q + prod_ext;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    len_d   = len;
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (beat) begin
                    a_d       = a;
                    b_d       = b;
                    p_valid_d = 1'b1;
                    count_d   = count_q + LEN_W'(1);
                    if (last_beat) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave once the final product has landed in the accumulator.
                if (!p_valid_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Saturation: in range when bits [ACC_W-1:31] are all equal.
    assign acc_top  = acc_q[ACC_W-1:PROD_W-1];
    assign in_range = (&acc_top) || !(|acc_top);
    assign sat_val  = in_range ? acc_q[31:0]
                    : (acc_q[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);

    // Handshake and status flags decode directly from the state register.
    assign in_ready  = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);

    // Result outputs are only meaningful in DONE; held at zero otherwise.
    assign out_acc   = out_valid ? acc_q : '0;
    assign out_sat   = out_valid ? sat_val : 32'h0;
    assign ovf       = out_valid && !in_range;

endmodule
